calc_display_scan: RTL and testbench

Display-side consumer of the calculator's digit-write interface. Captures `display_val`/`display_idx`/`display_wr` writes into an internal digit store and time-multiplexes the stored digits onto a common-anode, active-low 7-segment bank. Sits between the calculator core and the board's display pins, with a blanking gap between digits to suppress ghosting.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/calc_display_scan_seg7_decode.sv | 34 +++
 rtl/calc_display_scan.sv | 136 +++++++++++++
 tb/tb_calc_display_scan.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path: scan FSM states,
// special digit codes and the active-low segment patterns used by the decoder.
package calc_pkg;

    typedef enum logic {
        GAP,
        SHOW
    } scan_state_t;

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_E     = 4'hB;
    localparam logic [3:0] CODE_R     = 4'hC;
    localparam logic [3:0] CODE_O     = 4'hD;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_MINUS  = 7'h3F;

    // 0xE and 0xF both render dark.
    function automatic logic code_is_blank(input logic [3:0] code);
        return (code == 4'hE) || (code == CODE_BLANK);
    endfunction

endpackage

// File: rtl/calc_display_scan_seg7_decode.sv
// Combinational digit-code to active-low {g,f,e,d,c,b,a} pattern, with a
// blank override used by leading-zero blanking.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'h0:       seg = 7'h40;
                4'h1:       seg = 7'h79;
                4'h2:       seg = 7'h24;
                4'h3:       seg = 7'h30;
                4'h4:       seg = 7'h19;
                4'h5:       seg = 7'h12;
                4'h6:       seg = 7'h02;
                4'h7:       seg = 7'h78;
                4'h8:       seg = 7'h00;
                4'h9:       seg = 7'h10;
                CODE_MINUS: seg = SEG_MINUS;
                CODE_E:     seg = 7'h06;
                CODE_R:     seg = 7'h2F;
                CODE_O:     seg = 7'h23;
                default:    seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/calc_display_scan.sv
// Digit store plus time-multiplexed scan of a common-anode 7-segment bank.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZB_EN.
module calc_display_scan
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            display_val,
    input  logic [2:0]            display_idx,
    input  logic                  display_wr,
    input  logic                  display_clr,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int PTR_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_DIGITS - 1);

    scan_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [3:0]            mem_q [NUM_DIGITS];
    logic [3:0]            mem_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  lz_blank;
    logic [6:0]            dec_seg;

    // Clear takes effect before a same-cycle write, so the write survives.
    always_comb begin
        mem_d = mem_q;
        if (display_clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                mem_d[i] = CODE_BLANK;
            end
        end
        if (display_wr && (int'(display_idx) < NUM_DIGITS)) begin
            mem_d[display_idx[PTR_W-1:0]] = display_val;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        ptr_d   = ptr_q;
        case (state_q)
            GAP: begin
                if ((GAP_CYCLES == 0) || (cnt_q == GAP_LAST)) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? SHOW : GAP;
                end
            end
            default: begin
                state_d = GAP;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef DISPLAY_LZB_EN
    // A zero is blanked only when every more-significant digit is zero or dark.
    always_comb begin
        lz_blank = 1'b0;
        if ((ptr_d != '0) && (mem_q[ptr_d] == 4'h0)) begin
            lz_blank = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((i > int'(ptr_d)) && (mem_q[i] != 4'h0) && !code_is_blank(mem_q[i])) begin
                    lz_blank = 1'b0;
                end
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .code  (mem_q[ptr_d]),
        .blank (lz_blank),
        .seg   (dec_seg)
    );

    // Anode and segments are both derived from the next state so they move together.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (state_d == SHOW) begin
            an_d[ptr_d] = 1'b0;
            seg_d       = dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= GAP;
            cnt_q   <= '0;
            ptr_q   <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                mem_q[i] <= CODE_BLANK;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_calc_display_scan.sv
// Scoreboard bench for calc_display_scan: expected per-digit frames are queued
// by the stimulus and checked by a monitor at the start of each lit digit.
module tb_calc_display_scan;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
    } frame_t;

`ifdef DISPLAY_LZB_EN
    localparam logic [6:0] D1_ZERO_EXP = 7'h7F;
`else
    localparam logic [6:0] D1_ZERO_EXP = 7'h40;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] display_val = '0;
    logic [2:0] display_idx = '0;
    logic       display_wr  = 1'b0;
    logic       display_clr = 1'b0;
    logic [7:0] an8;
    logic [6:0] seg8;
    logic       dp8;
    logic [3:0] an4;
    logic [6:0] seg4;
    logic       dp4;

    int total = 0;
    int bad   = 0;

    frame_t     sb_q[$];
    logic [6:0] exp_seg [8];
    logic       timing_en = 1'b0;
    logic       run_valid = 1'b0;
    int         run_len   = 0;
    logic [7:0] prev_an   = 8'hFF;

    always #5 clk = ~clk;

    calc_display_scan #(.NUM_DIGITS(8), .REFRESH_DIV(4), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .display_val(display_val), .display_idx(display_idx),
        .display_wr(display_wr), .display_clr(display_clr), .an(an8), .seg(seg8), .dp(dp8)
    );

    calc_display_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GAP_CYCLES(1)) dut4 (
        .clk(clk), .rst(rst), .display_val(display_val), .display_idx(display_idx),
        .display_wr(display_wr), .display_clr(display_clr), .an(an4), .seg(seg4), .dp(dp4)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic push_scan();
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back('{an: 8'hFF ^ (8'd1 << i), seg: exp_seg[i]});
        end
    endtask

    task automatic set_all_blank();
        for (int i = 0; i < 8; i++) exp_seg[i] = 7'h7F;
    endtask

    task automatic apply_stimulus(input logic wr, input logic clr, input logic [2:0] idx, input logic [3:0] val);
        display_wr  = wr;
        display_clr = clr;
        display_idx = idx;
        display_val = val;
    endtask

    // Waits for a fresh transition of an8 to target, sampled on the falling edge.
    task automatic wait_start(input logic [7:0] target, input int budget);
        logic [7:0] last;
        logic       found;
        last  = an8;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            if ((an8 == target) && (last != target)) found = 1'b1;
            last = an8;
        end
        if (!found) check_output("wait_start timeout", 32'(an8), 32'(target));
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget && sb_q.size() != 0; n++) @(negedge clk);
        check_output("scoreboard drained", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: checks every new lit digit against the queue and the hold lengths.
    always @(negedge clk) begin
        frame_t e;
        int     exp_len;
        if (an8 != prev_an) begin
            if (run_valid && timing_en) begin
                exp_len = (prev_an == 8'hFF) ? 1 : 4;
                total++;
                if (run_len != exp_len) begin
                    bad++;
                    $display("[TB] FAIL hold length an=%h: got %0d, want %0d", prev_an, run_len, exp_len);
                end
            end
            run_len   = 1;
            run_valid = timing_en;
            if ((an8 != 8'hFF) && (sb_q.size() > 0)) begin
                e = sb_q.pop_front();
                total++;
                if ((an8 !== e.an) || (seg8 !== e.seg)) begin
                    bad++;
                    $display("[TB] FAIL scan frame: got an=%h seg=%h, want an=%h seg=%h", an8, seg8, e.an, e.seg);
                end
            end
        end else begin
            run_len++;
        end
        prev_an = an8;
    end

    initial begin
        int         err4;
        logic       seen2;
        logic [6:0] want4;

        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("reset an", 32'(an8), 32'hFF);
            check_output("reset seg", 32'(seg8), 32'h7F);
            check_output("reset dp", 32'(dp8), 32'h1);
        end
        rst = 1'b1;
        #1 check_output("an right after release", 32'(an8), 32'hFF);
        @(negedge clk);
        check_output("first an after release", 32'(an8), 32'hFE);
        check_output("first seg blank", 32'(seg8), 32'h7F);

        // Write latency: seg updates one edge after the capturing edge.
        apply_stimulus(1'b1, 1'b0, 3'd0, 4'd8);
        @(posedge clk);
        #1 check_output("seg at write edge", 32'(seg8), 32'h7F);
        apply_stimulus(1'b0, 1'b0, 3'd0, 4'd0);
        @(posedge clk);
        #1 check_output("seg one edge after write", 32'(seg8), 32'h00);
        check_output("an during latency", 32'(an8), 32'hFE);

        // Two free-running scans with digit 0 showing 8.
        wait_start(8'h7F, 100);
        @(negedge clk);
        set_all_blank();
        exp_seg[0] = 7'h00;
        push_scan();
        push_scan();
        timing_en = 1'b1;
        wait_drain(200);

        // Leading-zero case, written while digit 7 is lit.
        wait_start(8'h7F, 100);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 3'd1, 4'd0);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 3'd0, 4'd5);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 3'd0, 4'd0);
        set_all_blank();
        exp_seg[0] = 7'h12;
        exp_seg[1] = D1_ZERO_EXP;
        push_scan();
        wait_drain(100);

        // Fill with 1, then clear and write together, then an out-of-range write on dut4.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply_stimulus(1'b1, 1'b0, 3'(i), 4'd1);
        end
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 3'd0, 4'd0);
        wait_start(8'h7F, 100);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1, 3'd2, 4'd3);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 3'd7, 4'd1);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 3'd0, 4'd0);
        set_all_blank();
        exp_seg[2] = 7'h30;
        exp_seg[7] = 7'h79;
        push_scan();
        err4  = 0;
        seen2 = 1'b0;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (an4 != 4'hF) begin
                want4 = (an4 == 4'hB) ? 7'h30 : 7'h7F;
                if (an4 == 4'hB) seen2 = 1'b1;
                if ((seg4 != want4) || !((an4 == 4'hE) || (an4 == 4'hD) || (an4 == 4'hB) || (an4 == 4'h7))) begin
                    err4++;
                    $display("[TB] FAIL dut4 frame: got an=%h seg=%h, want seg=%h", an4, seg4, want4);
                end
            end
        end
        check_output("dut4 frame errors", 32'(err4), 32'd0);
        check_output("dut4 digit 2 lit", 32'(seen2), 32'd1);
        wait_drain(100);

        // Asynchronous reset between edges while a digit is lit.
        timing_en = 1'b0;
        wait_start(8'hFB, 100);
        #2 rst = 1'b0;
        #1 check_output("async reset an", 32'(an8), 32'hFF);
        check_output("async reset seg", 32'(seg8), 32'h7F);
        check_output("async reset an dut4", 32'(an4), 32'hF);
        set_all_blank();
        push_scan();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got running, want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
